// File: rtl/writeback_stage.sv
// writeback_stage
//   MEM/WB pipeline latch and register-file writer. Captures MEM-stage results
//   on every pipeline advance and picks the write-back value: the ALU result,
//   aligned and extended load data, or the JAL/JALR link address. Drives the
//   register file write port, latches HALT retirement and counts retired
//   instructions.
//
// Ports
//   i_clk, i_reset      clock; synchronous active-high reset
//   i_step              pipeline advance enable (0 = freeze)
//   i_valid             MEM slot holds a real instruction (0 = bubble)
//   i_reg_write         instruction writes a register
//   i_mem_to_reg        write value comes from load data
//   i_jal               write value is the link address (wins over mem_to_reg)
//   i_load_width        00 byte, 01 half, 1x word
//   i_load_unsigned     1 = zero-extend byte/half, 0 = sign-extend
//   i_addr_low          data address bits [1:0]
//   i_alu_result        ALU result
//   i_mem_data          raw word read from data memory
//   i_pc_plus8          link value
//   i_dest_reg          destination register
//   i_halt              instruction is HALT
//   o_wb_we/addr/data   register file write port (commits on next posedge)
//   o_halted            sticky: HALT has retired
//   o_retired_count     instructions retired since reset (wraps)
module writeback_stage #(
    parameter int NB   = 32,
    parameter int REGS = 5
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_step,
    input  logic            i_valid,
    input  logic            i_reg_write,
    input  logic            i_mem_to_reg,
    input  logic            i_jal,
    input  logic [1:0]      i_load_width,
    input  logic            i_load_unsigned,
    input  logic [1:0]      i_addr_low,
    input  logic [NB-1:0]   i_alu_result,
    input  logic [NB-1:0]   i_mem_data,
    input  logic [NB-1:0]   i_pc_plus8,
    input  logic [REGS-1:0] i_dest_reg,
    input  logic            i_halt,
    output logic            o_wb_we,
    output logic [REGS-1:0] o_wb_addr,
    output logic [NB-1:0]   o_wb_data,
    output logic            o_halted,
    output logic [31:0]     o_retired_count
);

    // Selects the addressed byte/half lane of the loaded word and extends it.
    function automatic logic [NB-1:0] load_extract(
        input logic [NB-1:0] word,
        input logic [1:0]    width,
        input logic [1:0]    lo,
        input logic          uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (width)
            2'b00:   return uns ? {{(NB-8){1'b0}}, b}  : {{(NB-8){b[7]}}, b};
            2'b01:   return uns ? {{(NB-16){1'b0}}, h} : {{(NB-16){h[15]}}, h};
            default: return word;
        endcase
    endfunction

    logic            vld_p1;
    logic            reg_write_p1;
    logic            mem_to_reg_p1;
    logic            jal_p1;
    logic [1:0]      load_width_p1;
    logic            load_unsigned_p1;
    logic [1:0]      addr_low_p1;
    logic [NB-1:0]   alu_p1;
    logic [NB-1:0]   mem_p1;
    logic [NB-1:0]   pc8_p1;
    logic [REGS-1:0] dest_p1;
    logic            halt_p1;
    logic            halted;
    logic [31:0]     retired_count;
    logic            halt_retiring;

    // A HALT retiring this step blocks capture of whatever is at the inputs.
    assign halt_retiring = vld_p1 & halt_p1;

    // ---- MEM -> WB boundary ----
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vld_p1           <= 1'b0;
            reg_write_p1     <= 1'b0;
            mem_to_reg_p1    <= 1'b0;
            jal_p1           <= 1'b0;
            load_width_p1    <= 2'b00;
            load_unsigned_p1 <= 1'b0;
            addr_low_p1      <= 2'b00;
            alu_p1           <= '0;
            mem_p1           <= '0;
            pc8_p1           <= '0;
            dest_p1          <= '0;
            halt_p1          <= 1'b0;
            halted           <= 1'b0;
            retired_count    <= '0;
        end else if (i_step) begin
            if (vld_p1 && !halted)
                retired_count <= retired_count + 32'd1;
            if (halt_retiring)
                halted <= 1'b1;
            if (!halted && !halt_retiring) begin
                vld_p1           <= i_valid;
                reg_write_p1     <= i_reg_write;
                mem_to_reg_p1    <= i_mem_to_reg;
                jal_p1           <= i_jal;
                load_width_p1    <= i_load_width;
                load_unsigned_p1 <= i_load_unsigned;
                addr_low_p1      <= i_addr_low;
                alu_p1           <= i_alu_result;
                mem_p1           <= i_mem_data;
                pc8_p1           <= i_pc_plus8;
                dest_p1          <= i_dest_reg;
                halt_p1          <= i_halt;
            end else begin
                vld_p1 <= 1'b0;
            end
        end
    end

    // ---- WB -> register file write port ----
    always_comb begin
        o_wb_we   = i_step & vld_p1 & reg_write_p1 & ~halt_p1
                    & (dest_p1 != '0) & ~halted;
        o_wb_addr = dest_p1;
        if (jal_p1)
            o_wb_data = pc8_p1;
        else if (mem_to_reg_p1)
            o_wb_data = load_extract(mem_p1, load_width_p1, addr_low_p1, load_unsigned_p1);
        else
            o_wb_data = alu_p1;
    end

    assign o_halted        = halted;
    assign o_retired_count = retired_count;

endmodule
